// File: rtl/spart_bus_driver.sv
// ---------------------------------------------------------------------------
// spart_bus_driver
//
// Sole bus master for the SPART UART. After reset it programs the baud
// divisor chosen by br_cfg (high byte, then low byte). It then echoes every
// received byte back out. Received bytes are buffered in a circular FIFO so
// reception keeps going while the transmitter is busy.
//
// Optional feature macro: SPART_BAUD_RECONFIG_EN
//    defined   : a br_cfg change seen while idle reprograms the divisor
//                and keeps the FIFO contents.
//    undefined : br_cfg is only sampled on the way out of reset.
//
// Ports:
//    clk        in   system clock, all state on the rising edge
//    rst        in   asynchronous active-high reset
//    br_cfg     in   baud select from switches (asynchronous, synchronised here)
//    rda        in   SPART receive data available
//    tbr        in   SPART transmit buffer ready
//    iocs       out  bus chip select, high only during an access cycle
//    iorw       out  1 = read from SPART, 0 = write to SPART
//    ioaddr     out  00 TX/RX buffer, 01 status, 10 divisor low, 11 divisor high
//    databus    io   driven only on write cycles, otherwise high-Z
//    fifo_count out  current FIFO occupancy
//    rx_stall   out  registered: rda was high while the FIFO was full
// ---------------------------------------------------------------------------
module spart_bus_driver #(
   parameter int CLK_FREQ   = 50000000,
   parameter int FIFO_DEPTH = 8,
   parameter int BAUD0      = 4800,
   parameter int BAUD1      = 9600,
   parameter int BAUD2      = 19200,
   parameter int BAUD3      = 38400
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [1:0]                  br_cfg,
   input  logic                        rda,
   input  logic                        tbr,
   output logic                        iocs,
   output logic                        iorw,
   output logic [1:0]                  ioaddr,
   inout  wire  [7:0]                  databus,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        rx_stall
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   // Rounded divisor for a 16x oversampling receiver.
   function automatic logic [15:0] div_of(input int baud);
      int d;
      d = (CLK_FREQ + 8 * baud) / (16 * baud);
      return d[15:0];
   endfunction

   localparam logic [15:0] DIV0 = div_of(BAUD0);
   localparam logic [15:0] DIV1 = div_of(BAUD1);
   localparam logic [15:0] DIV2 = div_of(BAUD2);
   localparam logic [15:0] DIV3 = div_of(BAUD3);

   typedef enum logic [2:0] {
      S_RESET,
      S_INIT_HI,
      S_INIT_LO,
      S_IDLE,
      S_RX_RD,
      S_TX_WR,
      S_GAP
   } state_t;

   state_t           state_q, state_d;
   logic             wait_q, wait_d;
   logic [1:0]       cfg_q, cfg_d;
   logic [1:0]       sync1_q, sync2_q;
   logic             iocs_q, iocs_d;
   logic             iorw_q, iorw_d;
   logic [1:0]       ioaddr_q, ioaddr_d;
   logic             drive_q, drive_d;
   logic [7:0]       dout_q, dout_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             stall_q, stall_d;
   logic [15:0]      div_sel;
   logic             full, empty, push, pop;
   logic [7:0]       mem [FIFO_DEPTH];

   // The synchroniser has no reset on purpose: it keeps sampling the switches
   // while rst is held, so the value latched on leaving reset is already valid.
   always_ff @(posedge clk) begin
      sync1_q <= br_cfg;
      sync2_q <= sync1_q;
   end

   assign full  = (count_q == CW'(FIFO_DEPTH));
   assign empty = (count_q == '0);

   // Push happens on the edge that closes a read cycle, pop on the edge
   // that closes a write cycle; the FSM never does both in one cycle.
   assign push = (state_q == S_RX_RD);
   assign pop  = (state_q == S_TX_WR);

   // Next-state logic. RESET spends one cycle waiting and latches the
   // synchronised baud select on its second edge. In IDLE, receive wins over
   // everything else so the SPART receiver is never overrun.
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      cfg_d   = cfg_q;
      case (state_q)
         S_RESET: begin
            if (wait_q) begin
               cfg_d   = sync2_q;
               state_d = S_INIT_HI;
            end else begin
               wait_d = 1'b1;
            end
         end
         S_INIT_HI: state_d = S_INIT_LO;
         S_INIT_LO: state_d = S_IDLE;
         S_IDLE: begin
            if (rda && !full) state_d = S_RX_RD;
`ifdef SPART_BAUD_RECONFIG_EN
            else if (sync2_q != cfg_q) begin
               cfg_d   = sync2_q;
               state_d = S_INIT_HI;
            end
`endif
            else if (tbr && !empty) state_d = S_TX_WR;
         end
         S_RX_RD:  state_d = S_GAP;
         S_TX_WR:  state_d = S_GAP;
         S_GAP:    state_d = S_IDLE;
         default:  state_d = S_RESET;
      endcase
   end

   // Divisor for the baud select being latched this cycle.
   always_comb begin
      div_sel = DIV0;
      case (cfg_d)
         2'd0: div_sel = DIV0;
         2'd1: div_sel = DIV1;
         2'd2: div_sel = DIV2;
         2'd3: div_sel = DIV3;
         default: div_sel = DIV0;
      endcase
   end

   // Bus outputs are decoded from the state being entered and registered,
   // so they are glitch-free and an asynchronous reset releases the bus at once.
   always_comb begin
      iocs_d   = 1'b0;
      iorw_d   = 1'b1;
      ioaddr_d = 2'b00;
      drive_d  = 1'b0;
      dout_d   = 8'h00;
      case (state_d)
         S_INIT_HI: begin
            iocs_d   = 1'b1;
            iorw_d   = 1'b0;
            ioaddr_d = 2'b11;
            drive_d  = 1'b1;
            dout_d   = div_sel[15:8];
         end
         S_INIT_LO: begin
            iocs_d   = 1'b1;
            iorw_d   = 1'b0;
            ioaddr_d = 2'b10;
            drive_d  = 1'b1;
            dout_d   = div_sel[7:0];
         end
         S_RX_RD: begin
            iocs_d = 1'b1;
         end
         S_TX_WR: begin
            iocs_d  = 1'b1;
            iorw_d  = 1'b0;
            drive_d = 1'b1;
            dout_d  = mem[rd_ptr_q];
         end
         default: ;
      endcase
   end

   // FIFO bookkeeping; pointers wrap naturally because the depth is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
         count_d  = count_q + CW'(1);
      end else if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
         count_d  = count_q - CW'(1);
      end
      stall_d = rda && full;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_RESET;
         wait_q   <= 1'b0;
         cfg_q    <= 2'b00;
         iocs_q   <= 1'b0;
         iorw_q   <= 1'b1;
         ioaddr_q <= 2'b00;
         drive_q  <= 1'b0;
         dout_q   <= 8'h00;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         stall_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         wait_q   <= wait_d;
         cfg_q    <= cfg_d;
         iocs_q   <= iocs_d;
         iorw_q   <= iorw_d;
         ioaddr_q <= ioaddr_d;
         drive_q  <= drive_d;
         dout_q   <= dout_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         stall_q  <= stall_d;
      end
   end

   // Storage needs no reset; emptiness is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= databus;
   end

   assign databus    = drive_q ? dout_q : 8'hzz;
   assign iocs       = iocs_q;
   assign iorw       = iorw_q;
   assign ioaddr     = ioaddr_q;
   assign fifo_count = count_q;
   assign rx_stall   = stall_q;

endmodule

// File: tb/tb_spart_bus_driver.sv
// ---------------------------------------------------------------------------
// tb_spart_bus_driver
//
// Bench for spart_bus_driver with default parameters. The bench plays the
// SPART: it drives a byte onto databus whenever the driver reads, and
// weak pull-ups make a released bus read back as 8'hFF.
// ---------------------------------------------------------------------------
module tb_spart_bus_driver;

   localparam int CLK_FREQ = 50000000;
   localparam int DEPTH    = 8;
   localparam int K_NONE   = 0;
   localparam int K_RD     = 1;
   localparam int K_WR     = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] br_cfg = 2'b01;
   logic       rda = 1'b0;
   logic       tbr = 1'b0;
   logic [7:0] rxByte = 8'h00;
   wire        iocs, iorw, rx_stall;
   wire  [1:0] ioaddr;
   wire  [7:0] databus;
   wire  [3:0] fifo_count;

   int nCompared   = 0;
   int nMismatched = 0;

   spart_bus_driver #(
      .CLK_FREQ   (CLK_FREQ),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .br_cfg     (br_cfg),
      .rda        (rda),
      .tbr        (tbr),
      .iocs       (iocs),
      .iorw       (iorw),
      .ioaddr     (ioaddr),
      .databus    (databus),
      .fifo_count (fifo_count),
      .rx_stall   (rx_stall)
   );

   always #5 clk = ~clk;

   // The SPART answers read cycles with the current receive byte.
   assign databus = (iocs === 1'b1 && iorw === 1'b1) ? rxByte : 8'hzz;

   for (genvar i = 0; i < 8; i++) begin : g_pull
      pullup (databus[i]);
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Divisor from baud rate, straight from the rounding rule.
   function automatic logic [15:0] divOf(input logic [1:0] sel);
      int b;
      int d;
      case (sel)
         2'd0: b = 4800;
         2'd1: b = 9600;
         2'd2: b = 19200;
         default: b = 38400;
      endcase
      d = (CLK_FREQ + 8 * b) / (16 * b);
      return d[15:0];
   endfunction

   // -----------------------------------------------------------------------
   // Reference model: a list of upcoming bus cycles plus a byte queue.
   // When no cycle is planned the driver is free to choose its next access.
   // -----------------------------------------------------------------------
   typedef struct {
      int         kind;
      logic [1:0] addr;
      logic [7:0] data;
   } act_t;

   act_t       plan[$];
   logic [7:0] fifoModel[$];
   logic [1:0] brPrev1 = 2'b01;
   logic [1:0] brPrev2 = 2'b01;
   logic [1:0] cfgModel = 2'b01;
   logic       stallPrev = 1'b0;
   bit         inReset = 1'b1;

   function automatic act_t mkAct(input int k, input logic [1:0] a, input logic [7:0] d);
      act_t r;
      r.kind = k;
      r.addr = a;
      r.data = d;
      return r;
   endfunction

   always @(negedge clk) begin
      act_t        cur;
      logic        stallNext;
      logic [15:0] dv;
      if (rst) begin
         checkOutput("rst_iocs", iocs, 1'b0);
         checkOutput("rst_iorw", iorw, 1'b1);
         checkOutput("rst_ioaddr", ioaddr, 2'b00);
         checkOutput("rst_databus", databus, 8'hFF);
         checkOutput("rst_count", fifo_count, 0);
         checkOutput("rst_stall", rx_stall, 1'b0);
         fifoModel.delete();
         plan.delete();
         stallPrev = 1'b0;
         inReset   = 1'b1;
      end else begin
         cur = mkAct(K_NONE, 2'b00, 8'h00);
         if (inReset) begin
            // First cycle after release: one more quiet cycle, then the divisor.
            inReset  = 1'b0;
            cfgModel = brPrev1;
            dv       = divOf(cfgModel);
            plan.push_back(mkAct(K_NONE, 2'b00, 8'h00));
            plan.push_back(mkAct(K_WR, 2'b11, dv[15:8]));
            plan.push_back(mkAct(K_WR, 2'b10, dv[7:0]));
         end else if (plan.size() > 0) begin
            cur = plan.pop_front();
         end else begin
            if (rda && fifoModel.size() < DEPTH) begin
               plan.push_back(mkAct(K_RD, 2'b00, 8'h00));
               plan.push_back(mkAct(K_NONE, 2'b00, 8'h00));
            end
`ifdef SPART_BAUD_RECONFIG_EN
            else if (brPrev2 != cfgModel) begin
               cfgModel = brPrev2;
               dv       = divOf(cfgModel);
               plan.push_back(mkAct(K_WR, 2'b11, dv[15:8]));
               plan.push_back(mkAct(K_WR, 2'b10, dv[7:0]));
            end
`endif
            else if (tbr && fifoModel.size() > 0) begin
               plan.push_back(mkAct(K_WR, 2'b00, fifoModel[0]));
               plan.push_back(mkAct(K_NONE, 2'b00, 8'h00));
            end
         end
         checkOutput("iocs", iocs, cur.kind != K_NONE);
         checkOutput("iorw", iorw, cur.kind != K_WR);
         checkOutput("ioaddr", ioaddr, cur.addr);
         if (cur.kind == K_WR) checkOutput("write_data", databus, cur.data);
         else if (cur.kind == K_NONE) checkOutput("bus_released", databus, 8'hFF);
         checkOutput("fifo_count", fifo_count, fifoModel.size());
         checkOutput("rx_stall", rx_stall, stallPrev);
         stallNext = rda && (fifoModel.size() == DEPTH);
         if (cur.kind == K_RD) fifoModel.push_back(rxByte);
         if (cur.kind == K_WR && cur.addr == 2'b00) void'(fifoModel.pop_front());
         stallPrev = stallNext;
      end
      brPrev2 = brPrev1;
      brPrev1 = br_cfg;
   end

   // One clock of stimulus, applied just after the rising edge.
   task automatic applyStimulus(input logic rdaV, input logic tbrV);
      @(posedge clk);
      #1;
      rda    = rdaV;
      tbr    = tbrV;
      rxByte = 8'($urandom);
   endtask

   // Release reset and watch the divisor programming sequence.
   task automatic releaseAndCheckInit(input logic [7:0] hi, input logic [7:0] lo);
      int pulses;
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (iocs === 1'b1) pulses++;
         if (i == 2) begin
            checkOutput("pin_init_hi_addr", ioaddr, 2'b11);
            checkOutput("pin_init_hi_data", databus, hi);
         end
         if (i == 3) begin
            checkOutput("pin_init_lo_addr", ioaddr, 2'b10);
            checkOutput("pin_init_lo_data", databus, lo);
         end
      end
      checkOutput("pin_init_pulses", pulses, 2);
   endtask

   initial begin
      int  pulses;
      bit  found;

      // Reset with 9600 baud selected: divisor 326 = 0x0146.
      releaseAndCheckInit(8'h01, 8'h46);

      // Single echo of 0x5A.
      @(posedge clk);
      #1;
      rda    = 1'b1;
      tbr    = 1'b1;
      rxByte = 8'h5A;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         if (k == 1) begin
            checkOutput("pin_echo_rd_cs", iocs, 1'b1);
            checkOutput("pin_echo_rd_rw", iorw, 1'b1);
         end
         if (k == 2) checkOutput("pin_echo_count1", fifo_count, 1);
         if (k == 4) begin
            checkOutput("pin_echo_wr_cs", iocs, 1'b1);
            checkOutput("pin_echo_wr_rw", iorw, 1'b0);
            checkOutput("pin_echo_wr_data", databus, 8'h5A);
         end
         if (k == 5) checkOutput("pin_echo_count0", fifo_count, 0);
         @(posedge clk);
         #1 rda = 1'b0;
      end

      // Two bursts with the transmitter blocked, then drained; the second wraps.
      for (int b = 0; b < 2; b++) begin
         repeat (30) applyStimulus(1'b1, 1'b0);
         @(negedge clk);
         checkOutput("pin_burst_full", fifo_count, 8);
         checkOutput("pin_burst_stall", rx_stall, 1'b1);
         repeat (30) applyStimulus(1'b0, 1'b1);
         @(negedge clk);
         checkOutput("pin_burst_drained", fifo_count, 0);
      end

      // One byte buffered, then rda and tbr together: the read goes first.
      applyStimulus(1'b1, 1'b0);
      repeat (5) applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1);
      @(negedge clk);
      checkOutput("pin_prio_rx_cs", iocs, 1'b1);
      checkOutput("pin_prio_rx_rw", iorw, 1'b1);
      repeat (10) applyStimulus(1'b0, 1'b1);

      // Change the baud switches while idle with one byte buffered.
      applyStimulus(1'b1, 1'b0);
      repeat (5) applyStimulus(1'b0, 1'b0);
      @(posedge clk);
      #1 br_cfg = 2'b11;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (iocs === 1'b1) pulses++;
      end
`ifdef SPART_BAUD_RECONFIG_EN
      checkOutput("pin_reconfig_pulses", pulses, 2);
`else
      checkOutput("pin_reconfig_pulses", pulses, 0);
`endif
      checkOutput("pin_reconfig_count", fifo_count, 1);
      repeat (6) applyStimulus(1'b0, 1'b1);

      // Randomised traffic with occasional switch changes.
      for (int c = 0; c < 2000; c++) begin
         applyStimulus($urandom_range(0, 9) < 4, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 199) == 0) br_cfg = 2'($urandom_range(0, 3));
      end

      // Reset in the middle of a transmit write.
      @(posedge clk);
      #1 br_cfg = 2'b11;
      repeat (10) applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1);
      found = 1'b0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (iocs === 1'b1 && iorw === 1'b0 && ioaddr === 2'b00) begin
            found = 1'b1;
            break;
         end
      end
      checkOutput("pin_tx_seen", found, 1'b1);
      #1;
      rst = 1'b1;
      rda = 1'b0;
      tbr = 1'b0;
      #1;
      checkOutput("pin_abort_cs", iocs, 1'b0);
      checkOutput("pin_abort_bus", databus, 8'hFF);
      checkOutput("pin_abort_count", fifo_count, 0);
      // 38400 baud after release: divisor 81 = 0x0051.
      releaseAndCheckInit(8'h00, 8'h51);

      repeat (5) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
